digit_uart_tx: RTL and testbench

DIGIT_UART_TX -- requirements
Module: digit_uart_tx

---
 rtl/digit_uart_tx.sv | 169 ++++++++++++++++
 tb/tb_digit_uart_tx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/digit_uart_tx.sv
// Four-digit decimal to ASCII UART transmitter: sends D3 D2 D1 D0 CR LF as 8N1 frames.
// Optional leading-zero suppression replaces leading zero digits with spaces.
module digit_uart_tx #(
  parameter int unsigned CLK_FREQ    = 50000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned SUPPRESS_LZ = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] digits,
  input  logic        start,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int unsigned BIT_CYCLES_RAW = CLK_FREQ / BAUD;
  localparam int unsigned BIT_CYCLES     = (BIT_CYCLES_RAW < 2) ? 2 : BIT_CYCLES_RAW;
  localparam int unsigned CNT_W          = $clog2(BIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_BIT,
    S_DATA,
    S_STOP,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [2:0]       char_idx_q, char_idx_d;
  logic [15:0]      digits_q, digits_d;
  logic             tx_q, tx_d;

  logic [3:0] nib;
  logic       is_digit;
  logic       lead_zero;
  logic [7:0] cur_char;
  logic       baud_end;

  // Character currently being framed, selected by char_idx_q from the latched digits.
  always_comb begin
    nib       = 4'h0;
    is_digit  = 1'b1;
    lead_zero = 1'b0;
    cur_char  = 8'h00;
    case (char_idx_q)
      3'd0: begin
        nib       = digits_q[15:12];
        lead_zero = (digits_q[15:12] == 4'h0);
      end
      3'd1: begin
        nib       = digits_q[11:8];
        lead_zero = (digits_q[15:8] == 8'h00);
      end
      3'd2: begin
        nib       = digits_q[7:4];
        lead_zero = (digits_q[15:4] == 12'h000);
      end
      3'd3: nib = digits_q[3:0];
      3'd4: is_digit = 1'b0;
      default: is_digit = 1'b0;
    endcase
    if (!is_digit) begin
      cur_char = (char_idx_q == 3'd4) ? 8'h0D : 8'h0A;
    end else if ((SUPPRESS_LZ != 0) && lead_zero) begin
      cur_char = 8'h20;
    end else if (nib > 4'd9) begin
      cur_char = 8'h3F;
    end else begin
      cur_char = 8'h30 + {4'h0, nib};
    end
  end

  assign baud_end = (baud_cnt_q == CNT_LAST);

  // tx_d carries the value of the bit that begins at the transition edge, so tx is registered.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    char_idx_d = char_idx_q;
    digits_d   = digits_q;
    tx_d       = tx_q;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (start) begin
          state_d    = S_START_BIT;
          digits_d   = digits;
          tx_d       = 1'b0;
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          char_idx_d = '0;
        end
      end
      S_START_BIT: begin
        baud_cnt_d = baud_cnt_q + 1'b1;
        if (baud_end) begin
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          state_d    = S_DATA;
          tx_d       = cur_char[0];
        end
      end
      S_DATA: begin
        baud_cnt_d = baud_cnt_q + 1'b1;
        if (baud_end) begin
          baud_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = cur_char[bit_idx_q + 3'd1];
          end
        end
      end
      S_STOP: begin
        baud_cnt_d = baud_cnt_q + 1'b1;
        if (baud_end) begin
          baud_cnt_d = '0;
          if (char_idx_q == 3'd5) begin
            state_d = S_DONE;
            tx_d    = 1'b1;
          end else begin
            char_idx_d = char_idx_q + 3'd1;
            state_d    = S_START_BIT;
            tx_d       = 1'b0;
          end
        end
      end
      S_DONE: begin
        state_d    = S_IDLE;
        char_idx_d = '0;
        tx_d       = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      char_idx_q <= '0;
      digits_q   <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      char_idx_q <= char_idx_d;
      digits_q   <= digits_d;
      tx_q       <= tx_d;
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q == S_START_BIT) || (state_q == S_DATA) || (state_q == S_STOP);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_digit_uart_tx.sv
// Bench for digit_uart_tx: two instances (plain and leading-zero suppression) share stimulus
// and every frame is checked against a reference built from the character rules.
module tb_digit_uart_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] digits;
  logic        tx0, busy0, done0;
  logic        tx1, busy1, done1;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  digit_uart_tx #(.CLK_FREQ(1000), .BAUD(100), .SUPPRESS_LZ(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .digits(digits), .start(start),
    .tx(tx0), .busy(busy0), .done(done0)
  );

  digit_uart_tx #(.CLK_FREQ(1000), .BAUD(100), .SUPPRESS_LZ(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .digits(digits), .start(start),
    .tx(tx1), .busy(busy1), .done(done1)
  );

  // Expected ASCII byte for message position pos (0 = thousands ... 5 = LF).
  function automatic logic [7:0] ref_char(input logic [15:0] d, input int pos, input bit sup);
    logic [15:0] upper;
    logic [3:0]  nib;
    if (pos == 4) return 8'h0D;
    if (pos == 5) return 8'h0A;
    upper = d >> (12 - 4 * pos);
    nib   = upper[3:0];
    if (sup && pos < 3 && upper == 16'h0000) return 8'h20;
    if (nib > 4'd9) return 8'h3F;
    return 8'h30 + {4'h0, nib};
  endfunction

  // Called at the first negedge after the accepting edge; samples 600 cycles of both lines.
  // At cycle perturb_at, digits are changed and start is pulsed to probe the busy behaviour.
  task automatic check_message(input logic [15:0] d, input string name, input int perturb_at);
    logic [10:0] obs0, obs1, exp0, exp1;
    int busy_bad;
    int cyc;
    busy_bad = 0;
    for (int c = 0; c < 6; c++) begin
      obs0 = '0;
      obs1 = '0;
      for (int b = 0; b < 10; b++) begin
        for (int j = 0; j < 10; j++) begin
          cyc = c * 100 + b * 10 + j;
          if (j == 0) begin
            obs0[b] = tx0;
            obs1[b] = tx1;
          end else begin
            if (tx0 !== obs0[b]) obs0[10] = 1'b1;
            if (tx1 !== obs1[b]) obs1[10] = 1'b1;
          end
          if (busy0 !== 1'b1 || busy1 !== 1'b1 || done0 !== 1'b0 || done1 !== 1'b0)
            busy_bad++;
          if (cyc == perturb_at) begin
            digits = 16'h5555;
            start  = 1'b1;
          end else begin
            start = 1'b0;
          end
          @(negedge clk);
        end
      end
      exp0 = {1'b0, 1'b1, ref_char(d, c, 1'b0), 1'b0};
      exp1 = {1'b0, 1'b1, ref_char(d, c, 1'b1), 1'b0};
      n_checks++;
      if (obs0 !== exp0) begin
        n_fail++;
        $display("FAIL %s lz0 char%0d: frame got %h expected %h", name, c, obs0, exp0);
      end
      n_checks++;
      if (obs1 !== exp1) begin
        n_fail++;
        $display("FAIL %s lz1 char%0d: frame got %h expected %h", name, c, obs1, exp1);
      end
    end
    n_checks++;
    if (busy_bad !== 0) begin
      n_fail++;
      $display("FAIL %s busy_window: %0d cycles without busy, required 0", name, busy_bad);
    end
    n_checks++;
    if ({done0, busy0, tx0, done1, busy1, tx1} !== 6'b101_101) begin
      n_fail++;
      $display("FAIL %s done_cycle: {done,busy,tx}x2 got %b expected 101101", name,
               {done0, busy0, tx0, done1, busy1, tx1});
    end
  endtask

  task automatic send(input logic [15:0] d, input string name, input int perturb_at);
    @(negedge clk);
    digits = d;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_message(d, name, perturb_at);
  endtask

  task automatic expect_idle_after(input string name);
    @(negedge clk);
    n_checks++;
    if ({done0, busy0, tx0, done1, busy1, tx1} !== 6'b001_001) begin
      n_fail++;
      $display("FAIL %s post_done: {done,busy,tx}x2 got %b expected 001001", name,
               {done0, busy0, tx0, done1, busy1, tx1});
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    start  = 1'b0;
    digits = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({done0, busy0, tx0, done1, busy1, tx1} !== 6'b001_001) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected 001001", {done0, busy0, tx0, done1, busy1, tx1});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({done0, busy0, tx0, done1, busy1, tx1} !== 6'b001_001) begin
      n_fail++;
      $display("FAIL reset_release_idle: got %b expected 001001",
               {done0, busy0, tx0, done1, busy1, tx1});
    end
  endtask

  task automatic test_fixed();
    send(16'h1234, "d1234", -1);
    expect_idle_after("d1234");
    send(16'h0045, "d0045", -1);
    expect_idle_after("d0045");
    send(16'h0000, "d0000", -1);
    expect_idle_after("d0000");
    send(16'h9A0F, "d9A0F", -1);
    expect_idle_after("d9A0F");
  endtask

  task automatic test_random();
    logic [15:0] d;
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 4; k++)
        d[k*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      send(d, "random", -1);
      expect_idle_after("random");
    end
  endtask

  task automatic test_ignore_busy();
    int bad;
    send(16'h1234, "busy_start", 100);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if ({done0, busy0, tx0, done1, busy1, tx1} !== 6'b001_001) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL no_queued_message: %0d active cycles, required 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    @(negedge clk);
    digits = 16'h4321;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (250) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({done0, busy0, tx0, done1, busy1, tx1} !== 6'b001_001) begin
      n_fail++;
      $display("FAIL async_abort: got %b expected 001001", {done0, busy0, tx0, done1, busy1, tx1});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if ({done0, busy0, tx0, done1, busy1, tx1} !== 6'b001_001) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL no_resume: %0d active cycles, required 0", bad);
    end
    send(16'h0907, "after_reset", -1);
    expect_idle_after("after_reset");
  endtask

  task automatic test_back_to_back();
    send(16'h0101, "b2b_first", -1);
    digits = 16'h8765;
    start  = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy0, tx0, busy1, tx1} !== 4'b0101) begin
      n_fail++;
      $display("FAIL start_in_done_ignored: {busy,tx}x2 got %b expected 0101", {busy0, tx0, busy1, tx1});
    end
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if ({busy0, tx0, busy1, tx1} !== 4'b1010) begin
      n_fail++;
      $display("FAIL start_after_done: {busy,tx}x2 got %b expected 1010", {busy0, tx0, busy1, tx1});
    end
    check_message(16'h8765, "b2b_second", -1);
    expect_idle_after("b2b_second");
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_random();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
